// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// FSM state encoding and register-file constants.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MULTI    = 2'd2
  } stall_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_stall_ctrl_load_use.sv
// Load-use RAW detector between ID and EXE.
// Writes to r0 never create a dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       exe_mem_to_reg,
  input  logic [4:0] exe_rd,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (exe_rd == id_rs);
  assign rt_hit = id_uses_rt && (exe_rd == id_rt);

  assign load_use = exe_mem_to_reg
                 && (exe_rd != REG_ZERO)
                 && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller feeding pipeline register
// freeze and bubble pins; priority miss > multi-cycle > load-use.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULTI_LAT = 32,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             exe_mem_to_reg,
  input  logic [4:0]       exe_rd,
  input  logic             exe_multi,
  input  logic             mem_cache_en,
  input  logic             cache_ready,
  output logic             freeze_front,
  output logic             freeze_id_exe,
  output logic             bubble_id_exe,
  output logic             freeze_exe_mem,
  output logic             bubble_exe_mem,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state
);

  localparam int LW = $clog2(MULTI_LAT);
  localparam logic [LW-1:0] LAT_INIT = LW'(MULTI_LAT - 2);

  stall_state_t state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic res_q, res_d;
  logic miss, load_use;
  logic ff, fie, bie, fem, bem;

  assign miss = mem_cache_en && !cache_ready;

  load_use_detect u_lud (
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .exe_mem_to_reg (exe_mem_to_reg),
    .exe_rd         (exe_rd),
    .load_use       (load_use)
  );

  // Next state, latency count and Mealy freeze/bubble decode
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    res_d   = res_q;
    ff      = 1'b0;
    fie     = 1'b0;
    bie     = 1'b0;
    fem     = 1'b0;
    bem     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (miss) begin
          {ff, fie, fem} = 3'b111;
          state_d = MEM_WAIT;
          res_d   = 1'b0;
        end else if (exe_multi) begin
          {ff, fie, bem} = 3'b111;
          lat_d   = LAT_INIT;
          state_d = MULTI;
        end else if (load_use) begin
          ff  = 1'b1;
          bie = 1'b1;
        end
      end
      MULTI: begin
        if (miss) begin
          {ff, fie, fem} = 3'b111;
          res_d   = 1'b1;
          state_d = MEM_WAIT;
        end else if (lat_q == '0) begin
          state_d = RUN;
        end else begin
          {ff, fie, bem} = 3'b111;
          lat_d = lat_q - LW'(1);
        end
      end
      MEM_WAIT: begin
        if (!cache_ready) begin
          {ff, fie, fem} = 3'b111;
        end else begin
          state_d = res_q ? MULTI : RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign freeze_front   = ff  && !rst;
  assign freeze_id_exe  = fie && !rst;
  assign bubble_id_exe  = bie && !rst;
  assign freeze_exe_mem = fem && !rst;
  assign bubble_exe_mem = bem && !rst;
  assign state          = state_q;

  // FSM state, multi-cycle latency and resume flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      lat_q   <= '0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      res_q   <= res_d;
    end
  end

  // Saturating count of front-end stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (freeze_front && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
